// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared sequencer state encoding for fetch control and decoder
package mips_pkg;

  // The decoder switches on these exact codes, so both sides import this type.
  typedef enum logic [1:0] {
    FETCH_S = 2'b00,
    EXEC1_S = 2'b01,
    EXEC2_S = 2'b10,
    HALT_S  = 2'b11
  } state_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/mips_stall_timer.sv
// rtl/mips_stall_timer.sv - saturating stall counter flagging a bus timeout
module mips_stall_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count consecutive stalled cycles, saturating at TIMEOUT; clear wins over stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Expire on the stall cycle that would make TIMEOUT consecutive stalls.
  assign expire = stall && (count == LAST);

endmodule

// File: rtl/mips_fetch_control.sv
// rtl/mips_fetch_control.sv - multicycle fetch/execute sequencer ahead of the MIPS decoder
module mips_fetch_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              waitrequest,
  input  logic [WORD_W-1:0] readdata,
  input  logic              halt_pc,
  input  logic              extra,
  input  logic              mem_access,
  output state_t            state,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] load_data,
  output logic              active,
  output logic              bus_error,
  output logic [CNT_W-1:0]  retired
);

  state_t            state_next;
  logic [WORD_W-1:0] instruction_next;
  logic [WORD_W-1:0] load_data_next;
  logic              bus_error_next;
  logic [CNT_W-1:0]  retired_next;

  logic fetch_stall;
  logic exec_stall;
  logic stall;
  logic clear;
  logic expire;

  // A halting PC beats a busy bus, so a halt never counts as a stall cycle.
  assign fetch_stall = (state == FETCH_S) && !halt_pc && waitrequest;
  assign exec_stall  = (state == EXEC1_S) && mem_access && waitrequest;
  assign stall       = fetch_stall || exec_stall;
  assign clear       = ((state == FETCH_S) && !halt_pc && !waitrequest) ||
                       ((state == EXEC1_S) && !exec_stall);

  mips_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .clear  (clear),
    .expire (expire)
  );

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH_S;
      instruction <= '0;
      load_data   <= '0;
      bus_error   <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_next;
      instruction <= instruction_next;
      load_data   <= load_data_next;
      bus_error   <= bus_error_next;
      retired     <= retired_next;
    end
  end

  // Next-state and register-update decisions for each sequencer state.
  always_comb begin
    state_next       = state;
    instruction_next = instruction;
    load_data_next   = load_data;
    bus_error_next   = bus_error;
    retired_next     = retired;
    case (state)
      FETCH_S: begin
        if (halt_pc) begin
          state_next = HALT_S;
        end else if (waitrequest) begin
          if (expire) begin
            state_next     = HALT_S;
            bus_error_next = 1'b1;
          end
        end else begin
          instruction_next = readdata;
          state_next       = EXEC1_S;
        end
      end
      EXEC1_S: begin
        if (exec_stall) begin
          if (expire) begin
            state_next     = HALT_S;
            bus_error_next = 1'b1;
          end
        end else if (extra) begin
          load_data_next = readdata;
          state_next     = EXEC2_S;
        end else begin
          retired_next = retired + CNT_W'(1);
          state_next   = FETCH_S;
        end
      end
      EXEC2_S: begin
        retired_next = retired + CNT_W'(1);
        state_next   = FETCH_S;
      end
      default: begin
        state_next = HALT_S;
      end
    endcase
  end

  // Core is live in every state except HALT.
  always_comb begin
    active = (state != HALT_S);
  end

endmodule

// File: tb/tb_mips_fetch_control.sv
// tb/tb_mips_fetch_control.sv - directed vector bench for mips_fetch_control
module tb_mips_fetch_control;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'h0;
  logic        halt_pc = 1'b0;
  logic        extra = 1'b0;
  logic        mem_access = 1'b0;

  state_t      state, state1;
  logic [31:0] instruction, load_data, instruction1, load_data1;
  logic        active, bus_error, active1, bus_error1;
  logic [3:0]  retired;
  logic [31:0] retired1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rd;
    logic        hp;
    logic        ex;
    logic        ma;
    logic [1:0]  st;
    logic [31:0] ins;
    logic [31:0] ld;
    logic        act;
    logic        be;
    logic [3:0]  ret;
  } vec_t;

  vec_t vecs[15];

  mips_fetch_control #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
    .halt_pc(halt_pc), .extra(extra), .mem_access(mem_access), .state(state),
    .instruction(instruction), .load_data(load_data), .active(active),
    .bus_error(bus_error), .retired(retired)
  );

  mips_fetch_control #(.TIMEOUT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
    .halt_pc(halt_pc), .extra(extra), .mem_access(mem_access), .state(state1),
    .instruction(instruction1), .load_data(load_data1), .active(active1),
    .bus_error(bus_error1), .retired(retired1)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wr, input logic [31:0] rd, input logic hp,
                              input logic ex, input logic ma, input logic [1:0] st,
                              input logic [31:0] ins, input logic [31:0] ld,
                              input logic act, input logic be, input logic [3:0] ret);
    vec_t v;
    v.wr = wr; v.rd = rd; v.hp = hp; v.ex = ex; v.ma = ma;
    v.st = st; v.ins = ins; v.ld = ld; v.act = act; v.be = be; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [1:0] st, input logic [31:0] ins,
                          input logic [31:0] ld, input logic act, input logic be,
                          input logic [3:0] ret);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".instruction"}, instruction, ins);
    chk({tag, ".load_data"}, load_data, ld);
    chk({tag, ".active"}, 32'(active), 32'(act));
    chk({tag, ".bus_error"}, 32'(bus_error), 32'(be));
    chk({tag, ".retired"}, 32'(retired), 32'(ret));
  endtask

  task automatic step(input logic wr, input logic [31:0] rd, input logic hp,
                      input logic ex, input logic ma);
    waitrequest = wr; readdata = rd; halt_pc = hp; extra = ex; mem_access = ma;
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one(input logic [31:0] rd);
    step(1'b0, rd, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0; readdata = 32'h0; halt_pc = 1'b0; extra = 1'b0; mem_access = 1'b0;
    #1;
    chk_main("reset", 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 32'h24020005, 1'b0, 1'b0, 1'b0, 2'd1, 32'h24020005, 32'h0, 1'b1, 1'b0, 4'd0);
    vecs[1]  = mk(1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h24020005, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[2]  = mk(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h24020005, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[3]  = mk(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h24020005, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[4]  = mk(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h24020005, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[5]  = mk(1'b0, 32'h8C430004, 1'b0, 1'b0, 1'b0, 2'd1, 32'h8C430004, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[6]  = mk(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 2'd1, 32'h8C430004, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[7]  = mk(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 2'd1, 32'h8C430004, 32'h0, 1'b1, 1'b0, 4'd1);
    vecs[8]  = mk(1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 2'd2, 32'h8C430004, 32'hDEADBEEF, 1'b1, 1'b0, 4'd1);
    vecs[9]  = mk(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h8C430004, 32'hDEADBEEF, 1'b1, 1'b0, 4'd2);
    vecs[10] = mk(1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 2'd1, 32'h00000001, 32'hDEADBEEF, 1'b1, 1'b0, 4'd2);
    vecs[11] = mk(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00000001, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3);
    vecs[12] = mk(1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3);
    vecs[13] = mk(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 2'd2, 32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0, 4'd3);
    vecs[14] = mk(1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0, 4'd4);

    // Table: 2-cycle instruction, stalled load, waitrequest ignored without mem_access.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].hp, vecs[i].ex, vecs[i].ma);
      chk_main($sformatf("vec%0d", i), vecs[i].st, vecs[i].ins, vecs[i].ld,
               vecs[i].act, vecs[i].be, vecs[i].ret);
    end

    // Halt wins over waitrequest, and HALT absorbs everything for 20 cycles.
    do_reset();
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_main("halt_entry", 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("halt_entry.t1_state", 32'(state1), 32'(HALT_S));
    chk("halt_entry.t1_bus_error", 32'(bus_error1), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(i[1], (i[0] ? 32'hFFFFFFFF : 32'h5A5A5A5A), 1'b0, 1'b1, 1'b1);
      chk($sformatf("halt_hold%0d.state", i), 32'(state), 32'(HALT_S));
    end
    chk_main("halt_end", 2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);

    // TIMEOUT=4 in FETCH: three stalls survive, the fourth halts with bus_error.
    do_reset();
    retire_one(32'h00000042);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      chk_main($sformatf("tmo_fetch%0d", i), 2'b00, 32'h42, 32'h0, 1'b1, 1'b0, 4'd1);
    end
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_main("tmo_fetch_halt", 2'b11, 32'h42, 32'h0, 1'b0, 1'b1, 4'd1);

    // Timeout in EXEC1: not retired, load_data untouched.
    do_reset();
    step(1'b0, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h77777777, 1'b0, 1'b1, 1'b1);
      chk_main($sformatf("tmo_exec%0d", i), 2'b01, 32'hAAAA0001, 32'h0, 1'b1, 1'b0, 4'd0);
    end
    step(1'b1, 32'h77777777, 1'b0, 1'b1, 1'b1);
    chk_main("tmo_exec_halt", 2'b11, 32'hAAAA0001, 32'h0, 1'b0, 1'b1, 4'd0);

    // TIMEOUT=1: the very first stall cycle halts.
    do_reset();
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1.state", 32'(state1), 32'(HALT_S));
    chk("t1.bus_error", 32'(bus_error1), 32'h1);
    chk("t1.main_state", 32'(state), 32'(FETCH_S));
    chk("t1.main_bus_error", 32'(bus_error), 32'h0);

    // Asynchronous reset mid-EXEC1 stall, observed before the next edge.
    do_reset();
    retire_one(32'h00000011);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0000ABCD, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    chk_main("pre_areset", 2'b01, 32'h0000ABCD, 32'h0, 1'b1, 1'b0, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_main("areset", 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("post_areset_stall%0d.state", i), 32'(state), 32'(FETCH_S));
    end
    step(1'b0, 32'h0000BEEF, 1'b0, 1'b0, 1'b0);
    chk_main("post_areset_fetch", 2'b01, 32'h0000BEEF, 32'h0, 1'b1, 1'b0, 4'd0);

    // Counter wrap: 16 retirements return a 4-bit counter to 0, 17 give 1.
    do_reset();
    for (int i = 0; i < 16; i++) retire_one(32'h00000100 + 32'(i));
    chk("wrap16.retired", 32'(retired), 32'h0);
    retire_one(32'h00000200);
    chk("wrap17.retired", 32'(retired), 32'h1);
    chk("wrap17.instruction", instruction, 32'h00000200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_control.md
# mips_fetch_control

Multicycle sequencer that sits directly upstream of the MIPS instruction decoder. It owns the `state` encoding the decoder switches on (FETCH/EXEC1/EXEC2/HALT). It latches the fetched instruction word and load data from the Avalon memory port, and stalls on `waitrequest`. It also halts the core on a PC-zero fetch or a bus timeout, and counts retired instructions.

## Interface
Parameters:
- `TIMEOUT`, default 1024: maximum consecutive stalled cycles before a bus error is declared. Must be ≥ 1.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `waitrequest` input 1: Avalon memory busy.
- `readdata` input 32: Avalon read data.
- `halt_pc` input 1: decoder `Halt`, asserted when the PC equals 0.
- `extra` input 1: decoder `Extra`; the instruction needs EXEC2.
- `mem_access` input 1: decoder `MemRead | MemWrite` during EXEC1.
- `state` output 2: 00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
- `instruction` output 32: instruction register, feeds the decoder.
- `load_data` output 32: registered load data, valid in EXEC2.
- `active` output 1: high while `state != HALT`.
- `bus_error` output 1: sticky; a stall exceeded `TIMEOUT`.
- `retired` output CNT_W: retired-instruction count.

## Operation
- Reset values:
  - `state` = FETCH.
  - `instruction` = 0.
  - `load_data` = 0.
  - `active` = 1.
  - `bus_error` = 0.
  - `retired` = 0.
  - Internal stall counter = 0.
- FETCH:
  - `halt_pc` = 1 takes priority: go to HALT and leave `instruction` unchanged.
  - Otherwise, if `waitrequest` = 1: stay in FETCH and increment the stall counter.
  - Otherwise: `instruction` ← `readdata`, go to EXEC1, clear the stall counter.
- EXEC1:
  - If `mem_access` and `waitrequest` are both 1: stay in EXEC1 and increment the stall counter.
  - Otherwise, clear the stall counter:
    - If `extra` = 1: `load_data` ← `readdata`, go to EXEC2.
    - If `extra` = 0: go to FETCH and increment `retired`.
  - `waitrequest` is ignored when `mem_access` = 0.
- EXEC2: go to FETCH unconditionally and increment `retired`. `waitrequest` is ignored.
- HALT:
  - Absorbing until `reset`; all inputs are ignored.
  - `instruction`, `load_data` and `retired` hold their values.
- Timeout:
  - The stall counter saturates at `TIMEOUT`.
  - A stall cycle in which the counter already equals `TIMEOUT - 1` sends the FSM to HALT and sets `bus_error` on the same edge.
- `retired` wraps modulo 2^CNT_W with no flag.
- `instruction` changes only on the FETCH→EXEC1 edge. `load_data` changes only on the EXEC1→EXEC2 edge.
- `active` is combinational from `state`. All other outputs are registered.

## Timing
- Minimum latency: 2-cycle instructions take 2 cycles (FETCH, EXEC1); load instructions take 3 cycles (FETCH, EXEC1, EXEC2).
- Each stalled cycle adds exactly 1 cycle.
- `instruction` is valid from the first EXEC1 cycle until the next FETCH→EXEC1 edge.
- `halt_pc` and `waitrequest` both high in FETCH: halt wins, and the stall counter does not increment.
- Timeout while in EXEC1: the instruction is not retired and `load_data` is not updated.
- Reset asserted in any state, including mid-stall or in HALT:
  - All registers return to their reset values immediately (asynchronous).
  - After `reset` deasserts, the first active edge evaluates FETCH.
- `TIMEOUT` = 1: the first stall cycle halts the core.

## Structure
- Shared package `mips_pkg`:
  - `state_t` enum with values `FETCH_S` = 2'b00, `EXEC1_S` = 2'b01, `EXEC2_S` = 2'b10, `HALT_S` = 2'b11.
  - Used by this block and the decoder so the encodings cannot diverge.
- One sub-module, `mips_stall_timer`:
  - Inputs: `clk`, `reset`, `stall`, `clear`.
  - Output: `expire`.
  - Saturating counter of width `$clog2(TIMEOUT + 1)`.
- Next-state logic in one `always_comb`; registers in one `always_ff` sensitive to `posedge clk or posedge reset`.

## Test plan
- 2-cycle instruction: reset, then `readdata` = 0x24020005 with `waitrequest` = 0 and `extra` = 0 → states FETCH, EXEC1, FETCH; `instruction` = 0x24020005; `retired` = 1.
- Load with stalls: FETCH with `waitrequest` high for 3 cycles, then `readdata` = 0x8C430004; EXEC1 with `mem_access` = 1, `extra` = 1, `waitrequest` high for 2 cycles, then `readdata` = 0xDEADBEEF → 8 cycles total; `load_data` = 0xDEADBEEF in EXEC2; `retired` = 1.
- Halt: `halt_pc` = 1 and `waitrequest` = 1 in FETCH → HALT on the next edge; `active` = 0; `bus_error` = 0; state stays HALT for 20 cycles while `readdata` toggles.
- Timeout with `TIMEOUT` = 4: hold `waitrequest` high in FETCH → HALT after exactly 4 stalled cycles; `bus_error` = 1; `retired` unchanged.
- Async reset: assert `reset` mid-EXEC1 stall, between clock edges → `state` = FETCH, `instruction` = 0 and `retired` = 0 before the next edge.
- Counter wrap with `CNT_W` = 4: retire 17 instructions → `retired` = 1.
